// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq).
// Sequences fetch/decode/execute/memory/writeback, stalls on a memory ready
// handshake, and counts retired instructions.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   opcode[6:0]     instruction register opcode field, valid from DECODE onward
//   zero            ALU zero flag for the current cycle
//   mem_ready       memory completes the current read/write this cycle
//   pc_write        PC load enable
//   ir_write        IR / old-PC load enable
//   adr_src         memory address select (0 PC, 1 ALUOut)
//   mem_read        memory read request
//   mem_write       memory write request
//   reg_write       register file write enable
//   result_src[1:0] result select (00 ALUOut, 01 mem data, 10 ALU result)
//   alu_src_a[1:0]  ALU A select (00 PC, 01 old PC, 10 rs1)
//   alu_src_b[1:0]  ALU B select (00 rs2, 01 immediate, 10 constant 4)
//   alu_op[1:0]     to ALU control (00 add, 01 sub, 10 funct-decoded)
//   illegal_instr   high while trapped on an unsupported opcode
//   state[3:0]      current state code
//   instret         retired instruction count
module multicycle_control #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 illegal_instr,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_EXEC_R    = 4'd7;
  localparam logic [3:0] S_EXEC_I    = 4'd8;
  localparam logic [3:0] S_ALU_WB    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]           state_q;
  logic [3:0]           state_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode; only FETCH/BRANCH strobes look at inputs
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_instr = 1'b0;
    retire_c      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Precompute branch target (old PC + imm) into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BRANCH:    state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // opcode[5] separates store (1) from load (0)
        state_d   = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        illegal_instr = 1'b1;
        state_d       = S_TRAP;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Retired instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        instret_q <= '0;
    else if (retire_c) instret_q <= instret_q + CNT_WIDTH'(1);
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Two instances (32-bit and 4-bit
// instret) share one stimulus stream so the counter wrap can be observed.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal_instr;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        pc_write4, ir_write4, adr_src4, mem_read4, mem_write4, reg_write4, illegal_instr4;
  logic [1:0]  result_src4, alu_src_a4, alu_src_b4, alu_op4;
  logic [3:0]  state4;
  logic [3:0]  instret4;

  // {pc ir adr mr mw rw}_{result_src}_{alu_src_a}_{alu_src_b}_{alu_op}_{illegal}
  logic [14:0] ctl;
  assign ctl = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};

  int checks = 0;
  int errors = 0;

  multicycle_control #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .state(state), .instret(instret)
  );

  multicycle_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write4), .ir_write(ir_write4), .adr_src(adr_src4), .mem_read(mem_read4),
    .mem_write(mem_write4), .reg_write(reg_write4), .result_src(result_src4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
    .illegal_instr(illegal_instr4), .state(state4), .instret(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL reset_ctl got=%b exp=0", ctl); end
    checks++; if (instret !== 32'd0 || instret4 !== 4'd0) begin errors++; $display("FAIL reset_instret got=%0d/%0d exp=0", instret, instret4); end
    rst_n = 1'b1;
    #2;
    checks++; if (state !== 4'd0 || ctl !== 15'd0) begin errors++; $display("FAIL idle_after_release state=%0d ctl=%b exp state=0 ctl=0", state, ctl); end
    opcode = 7'b0110011;
    step();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL fetch_state got=%0d exp=1", state); end
    checks++; if (ctl !== 15'b110100_10_00_10_00_0) begin errors++; $display("FAIL fetch_ctl got=%b exp=110100100010000", ctl); end
    step();
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL decode_state got=%0d exp=2", state); end
    checks++; if (ctl !== 15'b000000_00_01_01_00_0) begin errors++; $display("FAIL decode_ctl got=%b exp=000000000101000", ctl); end
  endtask

  // Entered in DECODE with an R-type opcode
  task automatic test_rtype;
    step();
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL exec_r_state got=%0d exp=7", state); end
    checks++; if (ctl !== 15'b000000_00_10_00_10_0) begin errors++; $display("FAIL exec_r_ctl got=%b exp=000000001000100", ctl); end
    step();
    checks++; if (state !== 4'd9) begin errors++; $display("FAIL alu_wb_state got=%0d exp=9", state); end
    checks++; if (ctl !== 15'b000001_00_00_00_00_0) begin errors++; $display("FAIL alu_wb_ctl got=%b exp=000001000000000", ctl); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rtype_instret_before got=%0d exp=0", instret); end
    step();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL rtype_back_fetch got=%0d exp=1", state); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL rtype_instret got=%0d exp=1", instret); end
  endtask

  // Entered in FETCH; three wait cycles in MEM_READ
  task automatic test_lw_wait;
    int edges;
    edges = 0;
    opcode = 7'b0000011; mem_ready = 1'b1;
    step(); edges++;
    step(); edges++;
    checks++; if (state !== 4'd3 || ctl !== 15'b000000_00_10_01_00_0) begin errors++; $display("FAIL mem_addr state=%0d ctl=%b exp state=3 ctl=000000001001000", state, ctl); end
    mem_ready = 1'b0;
    step(); edges++;
    checks++; if (state !== 4'd4 || ctl !== 15'b001100_00_00_00_00_0) begin errors++; $display("FAIL mem_read_enter state=%0d ctl=%b exp state=4 ctl=001100000000000", state, ctl); end
    for (int i = 0; i < 3; i++) begin
      step(); edges++;
      checks++; if (state !== 4'd4 || mem_read !== 1'b1 || adr_src !== 1'b1) begin errors++; $display("FAIL mem_read_hold%0d state=%0d mem_read=%b adr_src=%b exp 4/1/1", i, state, mem_read, adr_src); end
    end
    mem_ready = 1'b1;
    step(); edges++;
    checks++; if (state !== 4'd5 || ctl !== 15'b000001_01_00_00_00_0) begin errors++; $display("FAIL mem_wb state=%0d ctl=%b exp state=5 ctl=000001010000000", state, ctl); end
    checks++; if (edges !== 7) begin errors++; $display("FAIL lw_latency got=%0d exp=7", edges); end
    step();
    checks++; if (state !== 4'd1 || instret !== 32'd2) begin errors++; $display("FAIL lw_retire state=%0d instret=%0d exp 1/2", state, instret); end
  endtask

  // Entered in FETCH; stall fetch once, then a store with one wait cycle
  task automatic test_sw_stall;
    opcode = 7'b0100011; mem_ready = 1'b0;
    step();
    checks++; if (state !== 4'd1 || ctl !== 15'b000100_10_00_10_00_0) begin errors++; $display("FAIL fetch_stall state=%0d ctl=%b exp state=1 ctl=000100100010000", state, ctl); end
    mem_ready = 1'b1;
    #1;
    checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL fetch_ready ir=%b pc=%b exp 1/1", ir_write, pc_write); end
    step(); step();
    mem_ready = 1'b0;
    step();
    checks++; if (state !== 4'd6 || ctl !== 15'b001010_00_00_00_00_0) begin errors++; $display("FAIL mem_write state=%0d ctl=%b exp state=6 ctl=001010000000000", state, ctl); end
    step();
    checks++; if (state !== 4'd6 || instret !== 32'd2) begin errors++; $display("FAIL mem_write_wait state=%0d instret=%0d exp 6/2", state, instret); end
    mem_ready = 1'b1;
    step();
    checks++; if (state !== 4'd1 || instret !== 32'd3) begin errors++; $display("FAIL sw_retire state=%0d instret=%0d exp 1/3", state, instret); end
  endtask

  // Entered in FETCH; taken then not-taken beq
  task automatic test_beq;
    opcode = 7'b1100011; zero = 1'b1;
    step(); step();
    checks++; if (state !== 4'd10 || ctl !== 15'b100000_00_10_00_01_0) begin errors++; $display("FAIL beq_taken state=%0d ctl=%b exp state=10 ctl=100000001000010", state, ctl); end
    step();
    zero = 1'b0;
    step(); step();
    checks++; if (state !== 4'd10 || ctl !== 15'b000000_00_10_00_01_0) begin errors++; $display("FAIL beq_not_taken state=%0d ctl=%b exp state=10 ctl=000000001000010", state, ctl); end
    step();
    checks++; if (state !== 4'd1 || instret !== 32'd5) begin errors++; $display("FAIL beq_retire state=%0d instret=%0d exp 1/5", state, instret); end
  endtask

  // Entered in FETCH; illegal opcode traps until reset
  task automatic test_trap;
    opcode = 7'b1111111;
    step(); step();
    checks++; if (state !== 4'd15 || ctl !== 15'b000000_00_00_00_00_1) begin errors++; $display("FAIL trap_enter state=%0d ctl=%b exp state=15 ctl=000000000000001", state, ctl); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (state !== 4'd15 || illegal_instr !== 1'b1 || instret !== 32'd5) begin errors++; $display("FAIL trap_sticky%0d state=%0d illegal=%b instret=%0d exp 15/1/5", i, state, illegal_instr, instret); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || illegal_instr !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL trap_reset state=%0d illegal=%b instret=%0d exp 0/0/0", state, illegal_instr, instret); end
  endtask

  // Entered with reset asserted; 16 addi then a reset mid-EXEC_I
  task automatic test_wrap_and_async_reset;
    opcode = 7'b0010011; mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    for (int n = 1; n <= 16; n++) begin
      step(); step();
      if (n == 1) begin
        checks++; if (state !== 4'd8 || ctl !== 15'b000000_00_10_01_10_0) begin errors++; $display("FAIL exec_i state=%0d ctl=%b exp state=8 ctl=000000001001100", state, ctl); end
      end
      step(); step();
      if (n == 15) begin
        checks++; if (instret4 !== 4'd15 || instret !== 32'd15) begin errors++; $display("FAIL wrap_pre got=%0d/%0d exp=15/15", instret4, instret); end
      end
    end
    checks++; if (instret4 !== 4'd0) begin errors++; $display("FAIL wrap_4bit got=%0d exp=0", instret4); end
    checks++; if (instret !== 32'd16) begin errors++; $display("FAIL wrap_32bit got=%0d exp=16", instret); end
    step(); step();
    checks++; if (state !== 4'd8) begin errors++; $display("FAIL pre_reset_exec_i got=%0d exp=8", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || state4 !== 4'd0 || ctl !== 15'd0) begin errors++; $display("FAIL async_reset state=%0d/%0d ctl=%b exp 0/0/0", state, state4, ctl); end
    step();
    checks++; if (state !== 4'd0 || reg_write !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL reset_hold state=%0d reg_write=%b instret=%0d exp 0/0/0", state, reg_write, instret); end
    rst_n = 1'b1;
    step();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL restart_fetch got=%0d exp=1", state); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_stall();
    test_beq();
    test_trap();
    test_wrap_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I datapath (lw, sw, R-type ALU, I-type ALU, beq). It sequences fetch, decode, execute, memory and writeback.
- It drives the 2-bit alu_op consumed by the downstream ALU control unit: 00 add, 01 sub, 10 funct-decoded.
- It handles memory wait states through a ready handshake and keeps a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of instret counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instruction register bits [6:0]; valid from DECODE onward
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC register load enable
ir_write  out  1  instruction register / old-PC load enable
adr_src  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
result_src  out  2  result select: 00 ALUOut, 01 mem data, 10 ALU result
alu_src_a  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1 reg
alu_src_b  out  2  ALU B select: 00 rs2 reg, 01 immediate, 10 constant 4
alu_op  out  2  to ALU control unit
illegal_instr  out  1  high while in TRAP
state  out  4  current state code (debug/verification)
instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE and instret=0. All outputs are 0 while in IDLE.
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, EXEC_I 8, ALU_WB 9, BRANCH 10, TRAP 15. Codes 11-14 are unreachable and go to IDLE.
- Outputs are Moore, decoded from state. pc_write in FETCH/BRANCH depends on inputs as stated below. Any output not listed for a state is 0.
- IDLE: next state FETCH unconditionally (one cycle after reset release).
- FETCH:
  - mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - any other → TRAP
- MEM_ADDR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEM_READ if opcode[5]=0, else MEM_WRITE.
- MEM_READ: mem_read=1, adr_src=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Next FETCH.
- MEM_WRITE: mem_write=1, adr_src=1. Waits for mem_ready, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Next FETCH regardless of zero.
- TRAP: illegal_instr=1, all enables 0, sticky until reset. instret does not count the trapping instruction.
- Retirement: instret increments by 1 on each clock edge that leaves MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with mem_ready=1. It wraps from all-ones to 0.
- Memory handshake: mem_read/mem_write are held continuously until the cycle mem_ready=1. mem_ready is ignored in every other state.
- Reset mid-instruction: immediate return to IDLE; no partial strobe survives the asynchronous assertion.
- Cycle counts with mem_ready=1 every cycle: lw 5, sw 4, R/I 4, beq 3 (FETCH through last state).

Test Plan:
- Reset, release, mem_ready=1 → state sequence 0,1,2; all outputs 0 during reset and in IDLE.
- R-type (opcode 0110011): DECODE→EXEC_R with alu_op=10, alu_src_b=00; then ALU_WB with reg_write=1; instret 0→1.
- lw (0000011) with mem_ready held 0 for 3 cycles in MEM_READ → mem_read=1, adr_src=1 held 4 cycles total; MEM_WB with result_src=01; 7 cycles from FETCH.
- beq twice, zero=1 then zero=0 → BRANCH alu_op=01; pc_write=1 only in the first; instret +2.
- Opcode 1111111 → TRAP, illegal_instr=1 for 10+ cycles, instret unchanged; rst_n low → IDLE, illegal_instr=0.
- CNT_WIDTH=4, 16 consecutive addi (0010011) → instret wraps 15→0; rst_n pulsed low mid-EXEC_I → state=0 asynchronously, no reg_write.
